// File: rtl/operand_pkg.sv
// Shared operand types and sizing helpers for the operand-pair buffering path.
package operand_pkg;

    parameter int OPERAND_WIDTH = 4;

    typedef struct packed {
        logic [OPERAND_WIDTH-1:0] in1;
        logic [OPERAND_WIDTH-1:0] in2;
    } operand_pair_t;

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/operand_pair_fifo_if.sv
// Enqueue/dequeue handshake bundle plus status for the operand pair FIFO.
interface operand_pair_fifo_if
    import operand_pkg::*;
#(
    parameter int WIDTH = OPERAND_WIDTH,
    parameter int DEPTH = 4
);
    localparam int CNT_W = cnt_width(DEPTH);

    logic             enq_valid;
    logic             enq_ready;
    logic [WIDTH-1:0] enq_in1;
    logic [WIDTH-1:0] enq_in2;
    logic             deq_valid;
    logic             deq_ready;
    logic [WIDTH-1:0] deq_in1;
    logic [WIDTH-1:0] deq_in2;
    logic [CNT_W-1:0] count;
    logic             protocol_err;

    modport master (
        output enq_valid, enq_in1, enq_in2, deq_ready,
        input  enq_ready, deq_valid, deq_in1, deq_in2, count, protocol_err
    );

    modport slave (
        input  enq_valid, enq_in1, enq_in2, deq_ready,
        output enq_ready, deq_valid, deq_in1, deq_in2, count, protocol_err
    );

endinterface

// File: rtl/handshake_hold_checker.sv
// Sticky detector for a producer that drops valid or changes data while stalled.
module handshake_hold_checker #(
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              valid,
    input  logic              ready,
    input  logic [DATA_W-1:0] data,
    output logic              err
);

    logic              stall_r;
    logic [DATA_W-1:0] held_r;
    logic              err_r;
    logic              violation_s;

    // Compare this cycle's offer against the one that stalled last cycle.
    always_comb begin
        violation_s = 1'b0;
        if (stall_r) begin
            violation_s = ~valid | (data != held_r);
        end else begin
            violation_s = 1'b0;
        end
    end

    // Stall tracking, held-data capture and sticky error flag.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            stall_r <= 1'b0;
            held_r  <= {DATA_W{1'b0}};
            err_r   <= 1'b0;
        end else begin
            stall_r <= valid & ~ready;
            if (valid & ~ready) begin
                held_r <= data;
            end
            err_r <= err_r | violation_s;
        end
    end

    assign err = err_r;

endmodule

// File: rtl/operand_pair_fifo.sv
// Circular-buffer FIFO of {in1, in2} pairs with occupancy count and an
// upstream hold-violation flag; outputs depend on stored state only.
module operand_pair_fifo
    import operand_pkg::*;
#(
    parameter int WIDTH = OPERAND_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    operand_pair_fifo_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("operand_pair_fifo: DEPTH must be a power of two >= 2");
    end

    logic [2*WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic               enq_ready_s;
    logic               deq_valid_s;
    logic               enq_s;
    logic               deq_s;
    logic [2*WIDTH-1:0] head_s;
    logic               err_s;

    // Handshake qualifiers and head presentation; the head reads as zero when empty.
    always_comb begin
        enq_ready_s = (count_r != FULL_CNT);
        deq_valid_s = (count_r != {CNT_W{1'b0}});
        enq_s       = bus.enq_valid & enq_ready_s;
        deq_s       = deq_valid_s & bus.deq_ready;
        if (deq_valid_s) begin
            head_s = mem_r[rd_ptr_r];
        end else begin
            head_s = {2*WIDTH{1'b0}};
        end
    end

    // Drive the interface outputs.
    always_comb begin
        bus.enq_ready    = enq_ready_s;
        bus.deq_valid    = deq_valid_s;
        bus.deq_in1      = head_s[2*WIDTH-1:WIDTH];
        bus.deq_in2      = head_s[WIDTH-1:0];
        bus.count        = count_r;
        bus.protocol_err = err_s;
    end

    // Pair storage; deliberately left unreset since count gates visibility.
    always_ff @(posedge CLK) begin
        if (enq_s && !RESET) begin
            mem_r[wr_ptr_r] <= {bus.enq_in1, bus.enq_in2};
        end
    end

    // Pointers wrap naturally at DEPTH; count tracks the net enq/deq balance.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (enq_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (deq_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({enq_s, deq_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    handshake_hold_checker #(
        .DATA_W (2*WIDTH)
    ) u_hold_checker (
        .CLK   (CLK),
        .RESET (RESET),
        .valid (bus.enq_valid),
        .ready (enq_ready_s),
        .data  ({bus.enq_in1, bus.enq_in2}),
        .err   (err_s)
    );

endmodule

// File: tb/tb_operand_pair_fifo.sv
// Scoreboard bench: queue-based reference model updated on posedge, monitor on negedge.
module tb_operand_pair_fifo;
    import operand_pkg::*;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    operand_pair_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    operand_pair_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    operand_pair_t exp_q[$];
    int            model_count = 0;
    bit            model_err   = 1'b0;
    bit            prev_stall  = 1'b0;
    bit            mon_en      = 1'b0;
    operand_pair_t prev_pair;
    operand_pair_t cur_pair;
    bit            accept;
    bit            pop;

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: what the FIFO holds after each clock edge.
    always @(posedge CLK) begin
        cur_pair.in1 = bus.enq_in1;
        cur_pair.in2 = bus.enq_in2;
        if (RESET) begin
            exp_q.delete();
            model_count = 0;
            model_err   = 1'b0;
            prev_stall  = 1'b0;
            mon_en      = 1'b1;
        end else if (mon_en) begin
            if (prev_stall && (!bus.enq_valid || cur_pair != prev_pair)) model_err = 1'b1;
            prev_stall = bus.enq_valid && (model_count == DEPTH);
            prev_pair  = cur_pair;
            accept = bus.enq_valid && (model_count != DEPTH);
            pop    = bus.deq_ready && (model_count != 0);
            model_count = model_count + int'(accept) - int'(pop);
            if (accept) exp_q.push_back(cur_pair);
        end
    end

    // Monitor: status against the model, head data against the scoreboard queue.
    always @(negedge CLK) begin
        if (mon_en) begin
            check("count", int'(bus.count), model_count);
            check("enq_ready", int'(bus.enq_ready), int'(model_count != DEPTH));
            check("deq_valid", int'(bus.deq_valid), int'(model_count != 0));
            check("protocol_err", int'(bus.protocol_err), int'(model_err));
            if (bus.deq_valid) begin
                if (exp_q.size() == 0) begin
                    check("deq_unexpected", 1, 0);
                end else begin
                    check("deq_in1", int'(bus.deq_in1), int'(exp_q[0].in1));
                    check("deq_in2", int'(bus.deq_in2), int'(exp_q[0].in2));
                    if (bus.deq_ready) void'(exp_q.pop_front());
                end
            end else begin
                check("idle_in1", int'(bus.deq_in1), 0);
                check("idle_in2", int'(bus.deq_in2), 0);
            end
        end
    end

    task automatic step(input bit v, input logic [3:0] a, input logic [3:0] b,
                        input bit dr, input bit rst);
        bus.enq_valid = v;
        bus.enq_in1   = a;
        bus.enq_in2   = b;
        bus.deq_ready = dr;
        RESET         = rst;
        @(posedge CLK);
        #1;
    endtask

    task automatic fill_full();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 4'($urandom), 4'($urandom), 1'b0, 1'b0);
    endtask

    initial begin
        bit          v;
        bit          stalled;
        logic [3:0]  a;
        logic [3:0]  b;

        bus.enq_valid = 1'b0;
        bus.enq_in1   = 4'h0;
        bus.enq_in2   = 4'h0;
        bus.deq_ready = 1'b0;
        RESET         = 1'b1;

        step(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
        step(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
        check("rst_count", int'(bus.count), 0);
        check("rst_enq_ready", int'(bus.enq_ready), 1);
        check("rst_deq_valid", int'(bus.deq_valid), 0);
        check("rst_err", int'(bus.protocol_err), 0);
        check("rst_deq_in1", int'(bus.deq_in1), 0);

        // Single pair round trip.
        step(1'b1, 4'hA, 4'h3, 1'b0, 1'b0);
        check("single_valid", int'(bus.deq_valid), 1);
        check("single_in1", int'(bus.deq_in1), 'hA);
        check("single_in2", int'(bus.deq_in2), 'h3);
        check("single_count", int'(bus.count), 1);
        step(1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
        check("single_drained", int'(bus.count), 0);
        check("single_zero_in1", int'(bus.deq_in1), 0);
        check("single_zero_in2", int'(bus.deq_in2), 0);

        // Fill to full, hold a fifth pair until a slot frees.
        for (int i = 1; i <= 4; i++) step(1'b1, 4'(i), 4'(i), 1'b0, 1'b0);
        check("full_count", int'(bus.count), 4);
        check("full_enq_ready", int'(bus.enq_ready), 0);
        step(1'b1, 4'h5, 4'h5, 1'b0, 1'b0);
        check("full_held_count", int'(bus.count), 4);
        step(1'b1, 4'h5, 4'h5, 1'b1, 1'b0);
        check("slot_freed_ready", int'(bus.enq_ready), 1);
        check("slot_freed_count", int'(bus.count), 3);
        step(1'b1, 4'h5, 4'h5, 1'b0, 1'b0);
        check("refill_count", int'(bus.count), 4);
        repeat (3) step(1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
        check("tail_in1", int'(bus.deq_in1), 5);
        step(1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
        check("fill_err", int'(bus.protocol_err), 0);

        // Streaming at count=1 across several pointer wraps.
        step(1'b1, 4'($urandom), 4'($urandom), 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 4'($urandom), 4'($urandom), 1'b1, 1'b0);
            check("stream_count", int'(bus.count), 1);
        end
        step(1'b0, 4'h0, 4'h0, 1'b1, 1'b0);

        // Data change while stalled.
        fill_full();
        step(1'b1, 4'h7, 4'h0, 1'b0, 1'b0);
        check("hold_before", int'(bus.protocol_err), 0);
        step(1'b1, 4'h8, 4'h0, 1'b0, 1'b0);
        check("hold_change", int'(bus.protocol_err), 1);
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 4'h8, 4'h0, 1'b0, 1'b0);
            check("hold_sticky", int'(bus.protocol_err), 1);
        end
        step(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
        check("hold_cleared", int'(bus.protocol_err), 0);
        check("hold_rst_count", int'(bus.count), 0);

        // Valid dropped while stalled, then the same pattern without a stall.
        fill_full();
        step(1'b1, 4'h9, 4'h9, 1'b0, 1'b0);
        step(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        check("drop_stalled", int'(bus.protocol_err), 1);
        step(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
        step(1'b1, 4'h9, 4'h9, 1'b0, 1'b0);
        step(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        check("drop_unstalled", int'(bus.protocol_err), 0);
        step(1'b0, 4'h0, 4'h0, 1'b1, 1'b0);

        // Reset in the middle of traffic, with enq and deq in the reset cycle.
        repeat (3) step(1'b1, 4'($urandom), 4'($urandom), 1'b0, 1'b0);
        check("mid_count3", int'(bus.count), 3);
        step(1'b1, 4'hF, 4'hF, 1'b1, 1'b1);
        check("mid_count", int'(bus.count), 0);
        check("mid_deq_valid", int'(bus.deq_valid), 0);
        check("mid_enq_ready", int'(bus.enq_ready), 1);
        repeat (3) step(1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
        step(1'b1, 4'h6, 4'h2, 1'b0, 1'b0);
        check("post_rst_in1", int'(bus.deq_in1), 6);
        check("post_rst_in2", int'(bus.deq_in2), 2);
        step(1'b0, 4'h0, 4'h0, 1'b1, 1'b0);

        // Random traffic from a producer that honours the hold rule.
        stalled = 1'b0;
        v = 1'b0;
        a = 4'h0;
        b = 4'h0;
        for (int k = 0; k < 400; k++) begin
            if (!stalled) begin
                v = ($urandom_range(0, 3) != 0);
                a = 4'($urandom);
                b = 4'($urandom);
            end
            stalled = v && !bus.enq_ready;
            step(v, a, b, (k < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0), 1'b0);
        end
        check("compliant_err", int'(bus.protocol_err), 0);

        // Unconstrained random traffic, including hold violations.
        step(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
        for (int k = 0; k < 300; k++) begin
            step(1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom_range(0, 2) == 0), 1'b0);
        end
        repeat (DEPTH + 1) step(1'b0, 4'h0, 4'h0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
